// File: rtl/vh_result_unpacker.sv
// Reader side of the vloghammer result bus: captures a 90-bit packed result vector,
// streams its 18 extended fields over valid/ready and keeps a rotating XOR signature.
module vh_result_unpacker #(
    parameter int unsigned OUT_W    = 8,
    parameter logic [15:0] SIG_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [89:0]      in_y,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_idx,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             sig_valid,
    output logic [15:0]      sig_o,
    output logic [15:0]      vec_cnt
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_e;

    localparam logic [4:0] LAST_IDX = 5'd17;

    state_e      state_q, state_d;
    logic [89:0] hold_q, hold_d;
    logic [4:0]  idx_q, idx_d;
    logic [15:0] sig_q, sig_d;
    logic [15:0] sig_o_q, sig_o_d;
    logic        sig_valid_q, sig_valid_d;
    logic [15:0] vec_cnt_q, vec_cnt_d;

    logic [1:0]       grp_sel;
    logic [2:0]       fld_sel;
    logic [29:0]      grp;
    logic [OUT_W-1:0] field;
    logic             beat_acc;
    logic             capture;
    logic [15:0]      sig_next;

    // Field index k = 6g + s: pick the 30-bit group g, then the sub-field s inside it.
    always_comb begin
        if (idx_q < 5'd6) begin
            grp_sel = 2'd0;
            fld_sel = idx_q[2:0];
        end else if (idx_q < 5'd12) begin
            grp_sel = 2'd1;
            fld_sel = 3'(idx_q - 5'd6);
        end else begin
            grp_sel = 2'd2;
            fld_sel = 3'(idx_q - 5'd12);
        end

        case (grp_sel)
            2'd0:    grp = hold_q[89:60];
            2'd1:    grp = hold_q[59:30];
            default: grp = hold_q[29:0];
        endcase

        case (fld_sel)
            3'd0:    field = OUT_W'(grp[29:26]);
            3'd1:    field = OUT_W'(grp[25:21]);
            3'd2:    field = OUT_W'(grp[20:15]);
            3'd3:    field = OUT_W'($signed(grp[14:11]));
            3'd4:    field = OUT_W'($signed(grp[10:6]));
            3'd5:    field = OUT_W'($signed(grp[5:0]));
            default: field = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (beat_acc && out_last && !capture) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = (state_q == STREAM);
        out_last  = out_valid && (idx_q == LAST_IDX);
        out_idx   = idx_q;
        out_data  = out_valid ? field : '0;
        beat_acc  = out_valid && out_ready;
        in_ready  = (state_q == IDLE) || (out_last && out_ready);
        capture   = in_valid && in_ready;
        sig_valid = sig_valid_q;
        sig_o     = sig_o_q;
        vec_cnt   = vec_cnt_q;
    end

    // A capture on the last-beat accept overrides the idx/sig updates of that beat,
    // while the completed signature still lands in sig_o.
    always_comb begin
        hold_d      = hold_q;
        idx_d       = idx_q;
        sig_d       = sig_q;
        sig_o_d     = sig_o_q;
        sig_valid_d = 1'b0;
        vec_cnt_d   = vec_cnt_q;
        sig_next    = {sig_q[14:0], sig_q[15]} ^ 16'(out_data);

        if (beat_acc) begin
            sig_d = sig_next;
            if (out_last) begin
                idx_d       = '0;
                sig_o_d     = sig_next;
                sig_valid_d = 1'b1;
                vec_cnt_d   = vec_cnt_q + 16'd1;
            end else begin
                idx_d = idx_q + 5'd1;
            end
        end

        if (capture) begin
            hold_d = in_y;
            idx_d  = '0;
            sig_d  = SIG_SEED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q      <= '0;
            idx_q       <= '0;
            sig_q       <= '0;
            sig_o_q     <= '0;
            sig_valid_q <= 1'b0;
            vec_cnt_q   <= '0;
        end else begin
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            sig_q       <= sig_d;
            sig_o_q     <= sig_o_d;
            sig_valid_q <= sig_valid_d;
            vec_cnt_q   <= vec_cnt_d;
        end
    end

endmodule

// File: tb/tb_vh_result_unpacker.sv
// Self-checking bench for vh_result_unpacker against a field/signature reference model.
module tb_vh_result_unpacker;

    localparam int OUT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [89:0]      in_y;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_idx;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             sig_valid;
    logic [15:0]      sig_o;
    logic [15:0]      vec_cnt;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_cnt = '0;
    logic [15:0] exp_sig_o = '0;

    always #5 clk = ~clk;

    vh_result_unpacker #(.OUT_W(OUT_W), .SIG_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_y(in_y), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
        .out_last(out_last), .sig_valid(sig_valid), .sig_o(sig_o), .vec_cnt(vec_cnt)
    );

    // Field k from the packed layout: y[89-30g-C[s] -: W[s]], signed for s >= 3.
    function automatic logic [7:0] ref_field(input logic [89:0] y, input int k);
        int W[6];
        int C[6];
        int g, s, top;
        logic [7:0] v;
        W = '{4, 5, 6, 4, 5, 6};
        C = '{0, 4, 9, 15, 19, 24};
        g = k / 6;
        s = k % 6;
        top = 89 - 30 * g - C[s];
        v = '0;
        for (int b = 0; b < W[s]; b++) v[b] = y[top - W[s] + 1 + b];
        if (s >= 3 && v[W[s]-1]) for (int b = W[s]; b < 8; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] ref_sig(input logic [89:0] y);
        logic [15:0] sig;
        sig = 16'hACE1;
        for (int k = 0; k < 18; k++) sig = {sig[14:0], sig[15]} ^ {8'h00, ref_field(y, k)};
        return sig;
    endfunction

    function automatic logic [89:0] rand_vec();
        logic [89:0] v;
        v[31:0]  = $urandom();
        v[63:32] = $urandom();
        v[89:64] = 26'($urandom());
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_y = '0;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (sig_valid !== 1'b0) begin bad++; $display("FAIL reset_sig_valid got=%b exp=0", sig_valid); end
        total++; if (sig_o !== 16'h0) begin bad++; $display("FAIL reset_sig_o got=%h exp=0000", sig_o); end
        total++; if (vec_cnt !== 16'h0) begin bad++; $display("FAIL reset_vec_cnt got=%h exp=0000", vec_cnt); end
        total++; if ({out_idx, out_data, out_last} !== 14'h0) begin
            bad++; $display("FAIL reset_beat got idx=%0d data=%h last=%b exp all zero", out_idx, out_data, out_last);
        end
        rst_n = 1'b1;
        exp_cnt = '0;
        exp_sig_o = '0;
    endtask

    task automatic test_zero_vector();
        in_y = '0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int b = 0; b < 18; b++) begin
            total++;
            if ({out_valid, out_idx, out_data, out_last} !== {1'b1, 5'(b), 8'h00, (b == 17)}) begin
                bad++;
                $display("FAIL zero_beat%0d got v=%b idx=%0d data=%h last=%b exp v=1 idx=%0d data=00 last=%b",
                         b, out_valid, out_idx, out_data, out_last, b, (b == 17));
            end
            @(negedge clk);
        end
        exp_cnt++;
        exp_sig_o = 16'hB386;
        total++; if (sig_valid !== 1'b1) begin bad++; $display("FAIL zero_sig_valid got=%b exp=1", sig_valid); end
        total++; if (sig_o !== 16'hB386) begin bad++; $display("FAIL zero_sig got=%h exp=b386", sig_o); end
        total++; if (vec_cnt !== exp_cnt) begin bad++; $display("FAIL zero_vec_cnt got=%0d exp=%0d", vec_cnt, exp_cnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_idle got=%b exp=0", out_valid); end
    endtask

    task automatic test_pattern();
        logic [89:0] y;
        logic [7:0]  e;
        y = '0;
        y[89:86] = 4'hF;
        y[74:71] = 4'b1000;
        in_y = y; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int b = 0; b < 18; b++) begin
            e = (b == 0) ? 8'h0F : (b == 3) ? 8'hF8 : 8'h00;
            total++;
            if ({out_valid, out_idx, out_data} !== {1'b1, 5'(b), e}) begin
                bad++;
                $display("FAIL pattern_beat%0d got v=%b idx=%0d data=%h exp v=1 idx=%0d data=%h",
                         b, out_valid, out_idx, out_data, b, e);
            end
            @(negedge clk);
        end
        exp_cnt++;
        exp_sig_o = ref_sig(y);
        total++; if (sig_o !== exp_sig_o) begin bad++; $display("FAIL pattern_sig got=%h exp=%h", sig_o, exp_sig_o); end
        total++; if (vec_cnt !== exp_cnt) begin bad++; $display("FAIL pattern_vec_cnt got=%0d exp=%0d", vec_cnt, exp_cnt); end
    endtask

    task automatic test_random_stall(input int nvec);
        logic [89:0] cur_y, next_y;
        logic        active, want, pend, m_ready;
        int          beat, sent, cyc;
        active = 1'b0; want = 1'b0; beat = 0; sent = 0; cyc = 0;
        while ((sent < nvec || active) && cyc < 5000) begin
            out_ready = ($urandom() % 3) != 0;
            if (sent < nvec && !want) begin
                next_y = rand_vec();
                want = 1'b1;
            end
            in_valid = want && (($urandom() % 4) != 0);
            in_y = next_y;
            #1;
            m_ready = !active || (beat == 17 && out_ready);
            total++; if (in_ready !== m_ready) begin
                bad++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, m_ready);
            end
            pend = 1'b0;
            if (active && out_ready) begin
                if (beat == 17) begin
                    pend = 1'b1;
                    exp_sig_o = ref_sig(cur_y);
                    exp_cnt++;
                    active = 1'b0;
                    beat = 0;
                end else begin
                    beat++;
                end
            end
            if (in_valid && m_ready) begin
                cur_y = next_y; active = 1'b1; beat = 0; sent++; want = 1'b0;
            end
            @(negedge clk);
            cyc++;
            total++; if (sig_valid !== pend) begin bad++; $display("FAIL rand_sig_valid cyc=%0d got=%b exp=%b", cyc, sig_valid, pend); end
            total++; if (sig_o !== exp_sig_o) begin bad++; $display("FAIL rand_sig cyc=%0d got=%h exp=%h", cyc, sig_o, exp_sig_o); end
            total++; if (vec_cnt !== exp_cnt) begin bad++; $display("FAIL rand_vec_cnt cyc=%0d got=%0d exp=%0d", cyc, vec_cnt, exp_cnt); end
            total++;
            if (active) begin
                if ({out_valid, out_idx, out_data, out_last} !== {1'b1, 5'(beat), ref_field(cur_y, beat), (beat == 17)}) begin
                    bad++;
                    $display("FAIL rand_beat cyc=%0d got v=%b idx=%0d data=%h last=%b exp v=1 idx=%0d data=%h last=%b",
                             cyc, out_valid, out_idx, out_data, out_last, beat, ref_field(cur_y, beat), (beat == 17));
                end
            end else if (out_valid !== 1'b0) begin
                bad++; $display("FAIL rand_idle cyc=%0d got out_valid=%b exp=0", cyc, out_valid);
            end
        end
        in_valid = 1'b0;
        if (cyc >= 5000) begin
            total++; bad++; $display("FAIL rand_timeout sent=%0d got cycles=%0d exp<5000", sent, cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [89:0] y1, y2, y;
        int          pulses;
        y1 = rand_vec(); y2 = rand_vec(); pulses = 0;
        in_y = y1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_y = y2;
        for (int i = 0; i < 36; i++) begin
            y = (i < 18) ? y1 : y2;
            total++;
            if ({out_valid, out_idx, out_data} !== {1'b1, 5'(i % 18), ref_field(y, i % 18)}) begin
                bad++;
                $display("FAIL b2b_beat%0d got v=%b idx=%0d data=%h exp v=1 idx=%0d data=%h",
                         i, out_valid, out_idx, out_data, i % 18, ref_field(y, i % 18));
            end
            if (sig_valid) pulses++;
            if (i == 17) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
            end
            if (i == 18) begin
                in_valid = 1'b0;
                exp_cnt++;
                total++; if (sig_valid !== 1'b1 || sig_o !== ref_sig(y1)) begin
                    bad++; $display("FAIL b2b_sig1 got v=%b sig=%h exp v=1 sig=%h", sig_valid, sig_o, ref_sig(y1));
                end
            end
            @(negedge clk);
        end
        if (sig_valid) pulses++;
        exp_cnt++;
        exp_sig_o = ref_sig(y2);
        total++; if (sig_o !== exp_sig_o) begin bad++; $display("FAIL b2b_sig2 got=%h exp=%h", sig_o, exp_sig_o); end
        total++; if (pulses != 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
        total++; if (vec_cnt !== exp_cnt) begin bad++; $display("FAIL b2b_vec_cnt got=%0d exp=%0d", vec_cnt, exp_cnt); end
    endtask

    task automatic test_mid_reset();
        logic [89:0] y;
        y = rand_vec();
        in_y = y; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        total++; if (out_idx !== 5'd7) begin bad++; $display("FAIL mid_pre_idx got=%0d exp=7", out_idx); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        exp_sig_o = '0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
        total++; if (vec_cnt !== 16'h0) begin bad++; $display("FAIL mid_vec_cnt got=%0d exp=0", vec_cnt); end
        total++; if ({out_idx, out_data, out_last, sig_valid, sig_o} !== 31'h0) begin
            bad++; $display("FAIL mid_outputs got idx=%0d data=%h last=%b sv=%b sig=%h exp all zero",
                            out_idx, out_data, out_last, sig_valid, sig_o);
        end
        y = rand_vec();
        in_y = y; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int b = 0; b < 18; b++) begin
            total++;
            if ({out_valid, out_idx, out_data} !== {1'b1, 5'(b), ref_field(y, b)}) begin
                bad++;
                $display("FAIL mid_restart_beat%0d got v=%b idx=%0d data=%h exp v=1 idx=%0d data=%h",
                         b, out_valid, out_idx, out_data, b, ref_field(y, b));
            end
            @(negedge clk);
        end
        exp_cnt++;
        exp_sig_o = ref_sig(y);
        total++; if (sig_o !== exp_sig_o || vec_cnt !== exp_cnt) begin
            bad++; $display("FAIL mid_restart_sig got sig=%h cnt=%0d exp sig=%h cnt=%0d", sig_o, vec_cnt, exp_sig_o, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [89:0] y;
        @(negedge clk);
        force dut.vec_cnt_q = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        release dut.vec_cnt_q;
        total++; if (vec_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffff", vec_cnt); end
        y = rand_vec();
        in_y = y; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (18) @(negedge clk);
        exp_sig_o = ref_sig(y);
        total++; if (vec_cnt !== 16'h0) begin bad++; $display("FAIL wrap_vec_cnt got=%h exp=0000", vec_cnt); end
        total++; if (sig_valid !== 1'b1 || sig_o !== exp_sig_o) begin
            bad++; $display("FAIL wrap_sig got v=%b sig=%h exp v=1 sig=%h", sig_valid, sig_o, exp_sig_o);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_y = '0; out_ready = 1'b0;
        test_reset();
        test_zero_vector();
        test_pattern();
        test_random_stall(25);
        test_back_to_back();
        test_mid_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
